// File: rtl/gates_vec_pkg.sv
// Shared types, widths and the golden function of the 5-input SOP gate network.
package gates_vec_pkg;

   localparam int VEC_W = 5;
   localparam int CNT_W = VEC_W + 1;
   localparam int SET_W = 8;
   localparam int ERR_W = 6;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      DRIVE  = 3'd1,
      SETTLE = 3'd2,
      SAMPLE = 3'd3,
      REPORT = 3'd4,
      DONE   = 3'd5
   } state_t;

   // Vector bit order is {a,b,c,d,e}, a in the MSB.
   function automatic logic gates_golden(input logic [VEC_W-1:0] vec);
      logic va;
      logic vb;
      logic vc;
      logic vd;
      logic ve;
      {va, vb, vc, vd, ve} = vec;
      return (va & ~vb & ~vc) | (va & vb & ve) | (~vb & vc) | (vc & ~vd);
   endfunction

endpackage

// File: rtl/gates_ref_model.sv
// Combinational golden model of the gate network, evaluated on the current sweep vector.
module gates_ref_model
   import gates_vec_pkg::*;
(
   input  logic [VEC_W-1:0] vec,
   output logic             exp_y
);

   assign exp_y = gates_golden(vec);

endmodule

// File: rtl/gates_vec_sequencer.sv
// Drives vectors into the gate network, waits for it to settle, and reports y against the golden
// value over a valid/ready result channel.
module gates_vec_sequencer
   import gates_vec_pkg::*;
#(
   parameter int SETTLE_CYC = 4,
   parameter int FIRST_VEC  = 0,
   parameter int LAST_VEC   = 31
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   output logic             a,
   output logic             b,
   output logic             c,
   output logic             d,
   output logic             e,
   input  logic             y,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [VEC_W-1:0] res_vec,
   output logic             res_y,
   output logic             res_exp,
   output logic             res_err,
   output logic [ERR_W-1:0] err_cnt,
   output logic             busy,
   output logic             done
);

   localparam logic [CNT_W-1:0] FIRST_V     = CNT_W'(FIRST_VEC);
   localparam logic [CNT_W-1:0] LAST_V      = CNT_W'(LAST_VEC);
   localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYC - 1);

   state_t           state_r;
   state_t           state_s;
   logic [CNT_W-1:0] vec_r;
   logic [SET_W-1:0] settle_r;

   logic golden_s;
   logic err_s;
   logic abort_s;
   logic accept_s;
   logic last_s;
   logic clear_s;
   logic drive_s;
   logic settle_s;
   logic sample_s;
   logic release_s;
   logic advance_s;
   logic busy_s;
   logic done_s;

   gates_ref_model u_ref (
      .vec   (vec_r[VEC_W-1:0]),
      .exp_y (golden_s)
   );

   // The counter is one bit wider than a vector so that LAST_VEC=31 never wraps.
   assign abort_s  = abort && (state_r != IDLE);
   assign accept_s = res_valid && res_ready;
   assign last_s   = (vec_r == LAST_V);

   // Mismatch detect; an unknown y falls into the else branch and is counted as an error.
   always_comb begin
      err_s = 1'b1;
      if (y == golden_s) begin
         err_s = 1'b0;
      end else begin
         err_s = 1'b1;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic; abort overrides every transition outside IDLE.
   always_comb begin
      state_s = state_r;
      if (abort_s) begin
         state_s = IDLE;
      end else begin
         case (state_r)
            IDLE: begin
               if (start) state_s = DRIVE;
               else       state_s = IDLE;
            end
            DRIVE:  state_s = SETTLE;
            SETTLE: begin
               if (settle_r == SETTLE_LAST) state_s = SAMPLE;
               else                         state_s = SETTLE;
            end
            SAMPLE: state_s = REPORT;
            REPORT: begin
               if (accept_s && last_s) state_s = DONE;
               else if (accept_s)      state_s = DRIVE;
               else                    state_s = REPORT;
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
         endcase
      end
   end

   // Per-state datapath strobes and next values of the status outputs.
   always_comb begin
      clear_s   = 1'b0;
      drive_s   = 1'b0;
      settle_s  = 1'b0;
      sample_s  = 1'b0;
      release_s = 1'b0;
      advance_s = 1'b0;
      if (abort_s) begin
         clear_s = 1'b0;
      end else begin
         case (state_r)
            IDLE:   clear_s  = start;
            DRIVE:  drive_s  = 1'b1;
            SETTLE: settle_s = 1'b1;
            SAMPLE: sample_s = 1'b1;
            REPORT: begin
               release_s = accept_s;
               advance_s = accept_s && !last_s;
            end
            DONE:    clear_s = 1'b0;
            default: clear_s = 1'b0;
         endcase
      end
      busy_s = state_s inside {DRIVE, SETTLE, SAMPLE, REPORT};
      done_s = (state_s == DONE);
   end

   // Vector counter, settle counter and the vector presented to the network.
   always_ff @(posedge clk) begin
      if (rst) begin
         vec_r           <= {CNT_W{1'b0}};
         settle_r        <= {SET_W{1'b0}};
         {a, b, c, d, e} <= {VEC_W{1'b0}};
      end else begin
         if (clear_s)        vec_r <= FIRST_V;
         else if (advance_s) vec_r <= vec_r + CNT_W'(1);
         else                vec_r <= vec_r;

         if (drive_s)       settle_r <= {SET_W{1'b0}};
         else if (settle_s) settle_r <= settle_r + SET_W'(1);
         else               settle_r <= settle_r;

         if (drive_s) {a, b, c, d, e} <= vec_r[VEC_W-1:0];
         else         {a, b, c, d, e} <= {a, b, c, d, e};
      end
   end

   // Result channel, error count and status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         res_valid <= 1'b0;
         res_vec   <= {VEC_W{1'b0}};
         res_y     <= 1'b0;
         res_exp   <= 1'b0;
         res_err   <= 1'b0;
         err_cnt   <= {ERR_W{1'b0}};
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         busy <= busy_s;
         done <= done_s;

         if (sample_s) begin
            res_vec <= vec_r[VEC_W-1:0];
            res_y   <= y;
            res_exp <= golden_s;
            res_err <= err_s;
         end else begin
            res_vec <= res_vec;
            res_y   <= res_y;
            res_exp <= res_exp;
            res_err <= res_err;
         end

         if (clear_s)       err_cnt <= {ERR_W{1'b0}};
         else if (sample_s) err_cnt <= err_cnt + ERR_W'(err_s);
         else               err_cnt <= err_cnt;

         if (abort_s)        res_valid <= 1'b0;
         else if (sample_s)  res_valid <= 1'b1;
         else if (release_s) res_valid <= 1'b0;
         else                res_valid <= res_valid;
      end
   end

endmodule

// File: tb/tb_gates_vec_sequencer.sv
// Bench: five sequencer instances with different parameters, each driving its own delayed SOP network.
module tb_gates_vec_sequencer;

   localparam int N = 5;
   localparam int SC [N] = '{4, 1, 4, 4, 4};
   localparam int FV [N] = '{0, 0, 22, 30, 16};
   localparam int LV [N] = '{31, 31, 22, 30, 16};

   typedef struct packed { logic [4:0] vec; logic gold; } sb_item_t;
   typedef struct { int inst; logic [4:0] vec; logic gold; logic yv; } vec_rec_t;

   logic clk = 1'b0;
   logic rst;
   logic start [N];
   logic abort [N];
   logic res_ready [N];
   logic a [N];
   logic b [N];
   logic c [N];
   logic d [N];
   logic e [N];
   logic y [N];
   logic res_valid [N];
   logic res_y [N];
   logic res_exp [N];
   logic res_err [N];
   logic busy [N];
   logic done [N];
   logic [4:0] res_vec [N];
   logic [5:0] err_cnt [N];

   int n_cmp = 0;
   int n_bad = 0;
   int hs_cnt [N] = '{default: 0};
   int done_cnt [N] = '{default: 0};
   int errres_cnt [N] = '{default: 0};
   logic [4:0] last_vec [N];
   logic last_y [N];
   logic last_exp [N];
   logic last_err [N];
   time hs_prev_t = 0;
   time hs_last_t = 0;
   bit sb_on = 1'b0;
   sb_item_t sb_q [$];
   vec_rec_t tbl [3];

   always #5 clk = ~clk;

   for (genvar g = 0; g < N; g++) begin : g_dut
      logic ab_s, bb_s, cb_s, eb_s, nb_s, nc_s, nd_s;
      logic p0_s, p1_s, p2_s, p3_s;

      gates_vec_sequencer #(
         .SETTLE_CYC (SC[g]),
         .FIRST_VEC  (FV[g]),
         .LAST_VEC   (LV[g])
      ) u_dut (
         .clk       (clk),
         .rst       (rst),
         .start     (start[g]),
         .abort     (abort[g]),
         .a         (a[g]),
         .b         (b[g]),
         .c         (c[g]),
         .d         (d[g]),
         .e         (e[g]),
         .y         (y[g]),
         .res_valid (res_valid[g]),
         .res_ready (res_ready[g]),
         .res_vec   (res_vec[g]),
         .res_y     (res_y[g]),
         .res_exp   (res_exp[g]),
         .res_err   (res_err[g]),
         .err_cnt   (err_cnt[g]),
         .busy      (busy[g]),
         .done      (done[g])
      );

      // Every input-to-y path is 24 units: longer than two clocks' hold is short of, shorter than five.
      assign #6 ab_s = a[g];
      assign #6 bb_s = b[g];
      assign #6 cb_s = c[g];
      assign #6 eb_s = e[g];
      assign #6 nb_s = ~b[g];
      assign #6 nc_s = ~c[g];
      assign #6 nd_s = ~d[g];
      assign #8 p0_s = ab_s & nb_s & nc_s;
      assign #8 p1_s = ab_s & bb_s & eb_s;
      assign #8 p2_s = nb_s & cb_s;
      assign #8 p3_s = cb_s & nd_s;
      assign #10 y[g] = p0_s | p1_s | p2_s | p3_s;
   end

   function automatic logic tb_golden(input logic [4:0] v);
      return (v[4] & !v[3] & !v[2]) | (v[4] & v[3] & v[0]) | (!v[3] & v[2]) | (v[2] & !v[1]);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic check_reset(input string name, input int i);
      check(name, 32'({a[i], b[i], c[i], d[i], e[i], res_valid[i], res_vec[i], res_y[i],
                       res_exp[i], res_err[i], err_cnt[i], busy[i], done[i]}), 32'd0);
   endtask

   task automatic push_sweep();
      sb_q.delete();
      for (int v = 0; v < 32; v++) begin
         sb_q.push_back(sb_item_t'{vec: 5'(v), gold: tb_golden(5'(v))});
      end
   endtask

   // Handshake monitor and scoreboard; a transfer seen here completes at the next rising edge.
   always @(negedge clk) begin : mon
      sb_item_t it;
      for (int i = 0; i < N; i++) begin
         if (done[i] === 1'b1) begin
            done_cnt[i]++;
            check("busy_with_done", 32'(busy[i]), 32'd0);
         end
         if (res_valid[i] === 1'b1 && res_ready[i] === 1'b1) begin
            check("res_exp_golden", 32'(res_exp[i]), 32'(tb_golden(res_vec[i])));
            check("res_err_consistent", 32'(res_err[i]), 32'(res_y[i] !== res_exp[i]));
            if (res_err[i] === 1'b1) errres_cnt[i]++;
            last_vec[i] = res_vec[i];
            last_y[i]   = res_y[i];
            last_exp[i] = res_exp[i];
            last_err[i] = res_err[i];
            if (i == 0) begin
               hs_prev_t = hs_last_t;
               hs_last_t = $time;
               if (sb_on) begin
                  if (sb_q.size() == 0) begin
                     check("sb_unexpected_result", 32'(res_vec[0]), 32'hffff_ffff);
                  end else begin
                     it = sb_q.pop_front();
                     check("sb_result", 32'({res_vec[0], res_y[0], res_exp[0], res_err[0]}),
                           32'({it.vec, it.gold, it.gold, 1'b0}));
                  end
               end
            end
            hs_cnt[i]++;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1);
   end

   initial begin
      int lat;
      int guard;
      int base_hs;
      int base_done;

      rst = 1'b1;
      for (int i = 0; i < N; i++) begin
         start[i] = 1'b0;
         abort[i] = 1'b0;
         res_ready[i] = 1'b1;
      end
      tbl[0] = '{2, 5'b10110, 1'b1, 1'b1};
      tbl[1] = '{3, 5'b11110, 1'b0, 1'b0};
      tbl[2] = '{4, 5'b10000, 1'b1, 1'b1};

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < N; i++) check_reset("reset_state", i);

      // Full default sweep on instance 0 and short-settle sweep on instance 1.
      push_sweep();
      sb_on = 1'b1;
      start[0] = 1'b1;
      start[1] = 1'b1;
      @(posedge clk); #1;
      start[0] = 1'b0;
      start[1] = 1'b0;
      lat = 1;
      while (res_valid[0] !== 1'b1 && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      check("start_to_valid", 32'(lat), 32'(SC[0] + 3));
      check("busy_in_sweep", 32'(busy[0]), 32'd1);
      guard = 0;
      while (hs_cnt[0] < 2 && guard < 100) begin
         @(posedge clk); #2;
         guard++;
      end
      check("result_interval", 32'(hs_last_t - hs_prev_t), 32'd70);
      guard = 0;
      while ((done_cnt[0] < 1 || done_cnt[1] < 1) && guard < 600) begin
         @(posedge clk); #2;
         guard++;
      end
      check("sweep_done_in_time", 32'(guard < 600), 32'd1);
      repeat (3) @(posedge clk);
      #1;
      check("t1_result_count", 32'(hs_cnt[0]), 32'd32);
      check("t1_sb_drained", 32'(sb_q.size()), 32'd0);
      check("t1_err_cnt", 32'(err_cnt[0]), 32'd0);
      check("t1_done_once", 32'(done_cnt[0]), 32'd1);
      check("t1_idle_after", 32'(busy[0]), 32'd0);
      check("t3_result_count", 32'(hs_cnt[1]), 32'd32);
      check("t3_err_result_seen", 32'(errres_cnt[1] > 0), 32'd1);
      check("t3_err_cnt_nonzero", 32'(err_cnt[1] != 6'd0), 32'd1);
      check("t3_err_cnt_matches", 32'(err_cnt[1]), 32'(errres_cnt[1]));
      check("t3_done_once", 32'(done_cnt[1]), 32'd1);

      // Single-vector sweeps, checked from the table.
      sb_on = 1'b0;
      for (int k = 2; k < N; k++) start[k] = 1'b1;
      @(posedge clk); #1;
      for (int k = 2; k < N; k++) start[k] = 1'b0;
      guard = 0;
      while ((done_cnt[2] < 1 || done_cnt[3] < 1 || done_cnt[4] < 1) && guard < 60) begin
         @(posedge clk); #2;
         guard++;
      end
      for (int k = 0; k < 3; k++) begin
         check("single_vector",
               32'({8'(hs_cnt[tbl[k].inst]), 8'(done_cnt[tbl[k].inst]), last_vec[tbl[k].inst],
                    last_y[tbl[k].inst], last_exp[tbl[k].inst], last_err[tbl[k].inst]}),
               32'({8'd1, 8'd1, tbl[k].vec, tbl[k].yv, tbl[k].gold, 1'b0}));
      end

      // Backpressure on the first result, then abort at vector 7.
      push_sweep();
      sb_on = 1'b1;
      base_hs = hs_cnt[0];
      base_done = done_cnt[0];
      res_ready[0] = 1'b0;
      start[0] = 1'b1;
      @(posedge clk); #1;
      start[0] = 1'b0;
      guard = 0;
      while (res_valid[0] !== 1'b1 && guard < 40) begin
         @(posedge clk); #1;
         guard++;
      end
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         check("bp_hold", 32'({res_valid[0], res_vec[0], res_y[0], res_exp[0], res_err[0],
                               a[0], b[0], c[0], d[0], e[0]}),
               32'({1'b1, 5'd0, tb_golden(5'd0), tb_golden(5'd0), 1'b0, 5'd0}));
      end
      check("bp_no_transfer", 32'(hs_cnt[0] - base_hs), 32'd0);
      res_ready[0] = 1'b1;
      @(posedge clk); #1;
      check("bp_release", 32'({res_valid[0], a[0], b[0], c[0], d[0], e[0]}), 32'({1'b0, 5'd0}));
      @(posedge clk); #1;
      check("bp_advance", 32'({a[0], b[0], c[0], d[0], e[0]}), 32'd1);
      guard = 0;
      while ({a[0], b[0], c[0], d[0], e[0]} !== 5'd7 && guard < 100) begin
         @(posedge clk); #1;
         guard++;
      end
      check("reach_vec7", 32'(guard < 100), 32'd1);
      abort[0] = 1'b1;
      @(posedge clk); #1;
      abort[0] = 1'b0;
      check("abort_state", 32'({busy[0], res_valid[0], done[0], a[0], b[0], c[0], d[0], e[0]}),
            32'({3'b000, 5'd7}));
      check("abort_results", 32'(hs_cnt[0] - base_hs), 32'd7);
      repeat (3) @(posedge clk);
      #1;
      check("abort_no_done", 32'(done_cnt[0] - base_done), 32'd0);
      check("abort_stays_idle", 32'({busy[0], res_valid[0], a[0], b[0], c[0], d[0], e[0]}), 32'd7);

      // Restart from FIRST_VEC; instance 1 restarts too so its err_cnt clear is visible.
      push_sweep();
      base_hs = hs_cnt[0];
      base_done = done_cnt[0];
      start[0] = 1'b1;
      start[1] = 1'b1;
      @(posedge clk); #1;
      start[0] = 1'b0;
      start[1] = 1'b0;
      check("restart_err_cnt_cleared", 32'(err_cnt[1]), 32'd0);
      for (int k = 0; k < 2; k++) begin
         repeat (45) @(posedge clk);
         #1 start[0] = 1'b1;
         @(posedge clk); #1;
         start[0] = 1'b0;
      end
      guard = 0;
      while (done_cnt[0] == base_done && guard < 600) begin
         @(posedge clk); #2;
         guard++;
      end
      repeat (3) @(posedge clk);
      #1;
      check("restart_result_count", 32'(hs_cnt[0] - base_hs), 32'd32);
      check("restart_sb_drained", 32'(sb_q.size()), 32'd0);
      check("restart_done_once", 32'(done_cnt[0] - base_done), 32'd1);

      // Reset while a result waits in REPORT.
      sb_on = 1'b0;
      res_ready[0] = 1'b0;
      start[0] = 1'b1;
      @(posedge clk); #1;
      start[0] = 1'b0;
      guard = 0;
      while (res_valid[0] !== 1'b1 && guard < 40) begin
         @(posedge clk); #1;
         guard++;
      end
      check("report_reached", 32'(res_valid[0]), 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check_reset("rst_in_report", 0);
      repeat (5) @(posedge clk);
      #1;
      check_reset("idle_after_rst", 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
